// File: rtl/uart_program_loader.sv
// Boot loader that receives a program image over 8N1 UART and writes it into
// the core's instruction memory through the program_in/address_in load path.
// The core is held in reset until the image has been fully written.
// Image format: 0xA5, word count N (16 bits, low byte first), then N
// little-endian 32-bit words.
// Optional build macro LOADER_CHECKSUM_EN: a trailing byte holding the
// modulo-256 sum of all data bytes is expected and verified before the
// core is released.
module uart_program_loader #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 10,
    parameter int unsigned ClksPerBit = 868
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DataWidth-1:0] program_out,
    output logic [AddrWidth-1:0] address_out,
    output logic                 write_en,
    output logic                 core_reset,
    output logic                 load_done,
    output logic                 frame_err,
    output logic                 ovf_err,
    output logic                 chk_err
);

    localparam int unsigned CntW    = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned HalfBit = ClksPerBit / 2;
    localparam int unsigned LenW    = 16;
    localparam int unsigned WcntW   = LenW + 1;
    localparam logic [7:0]  SyncByte = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE
    } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_t ImageEnd = CHECK;
`else
    localparam ld_state_t ImageEnd = DONE;
`endif

    // ------------------------------------------------------------------
    // RX front end
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    rx_state_t       rx_state,   rx_state_nxt;
    logic [CntW-1:0] bit_cnt,    bit_cnt_nxt;
    logic [2:0]      bit_idx,    bit_idx_nxt;
    logic [7:0]      rx_shift,   rx_shift_nxt;
    logic            byte_valid, byte_valid_nxt;
    logic            frame_evt,  frame_evt_nxt;

    // Two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_evt  <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            rx_shift   <= rx_shift_nxt;
            byte_valid <= byte_valid_nxt;
            frame_evt  <= frame_evt_nxt;
        end
    end

    // Receiver next state: mid-start recheck, mid-bit data sampling, stop check
    always_comb begin
        rx_state_nxt   = rx_state;
        bit_cnt_nxt    = bit_cnt + CntW'(1);
        bit_idx_nxt    = bit_idx;
        rx_shift_nxt   = rx_shift;
        byte_valid_nxt = 1'b0;
        frame_evt_nxt  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                bit_cnt_nxt = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (bit_cnt == CntW'(HalfBit - 1)) begin
                    bit_cnt_nxt  = '0;
                    bit_idx_nxt  = '0;
                    // a line back high at mid-start is a glitch
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_cnt == CntW'(ClksPerBit - 1)) begin
                    bit_cnt_nxt  = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    bit_idx_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (bit_cnt == CntW'(ClksPerBit - 1)) begin
                    bit_cnt_nxt  = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid_nxt = 1'b1;
                    end else begin
                        frame_evt_nxt = 1'b1;
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Image loader
    // ------------------------------------------------------------------
    ld_state_t            ld_state, ld_state_nxt;
    logic [LenW-1:0]      len,      len_nxt;
    logic [23:0]          word_lo,  word_lo_nxt;
    logic [1:0]           byte_idx, byte_idx_nxt;
    logic [WcntW-1:0]     word_cnt, word_cnt_nxt;
    logic [7:0]           cksum,    cksum_nxt;
    logic [DataWidth-1:0] program_out_nxt;
    logic [AddrWidth-1:0] address_out_nxt;
    logic                 write_en_nxt;
    logic                 core_reset_nxt;
    logic                 load_done_nxt;
    logic                 frame_err_nxt;
    logic                 ovf_err_nxt;
    logic                 chk_err_nxt;
    logic                 last_word;
    logic                 word_ovf;

    // Loader state and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ld_state    <= WAIT_SYNC;
            len         <= '0;
            word_lo     <= '0;
            byte_idx    <= '0;
            word_cnt    <= '0;
            cksum       <= '0;
            program_out <= '0;
            address_out <= '0;
            write_en    <= 1'b0;
            core_reset  <= 1'b1;
            load_done   <= 1'b0;
            frame_err   <= 1'b0;
            ovf_err     <= 1'b0;
            chk_err     <= 1'b0;
        end else begin
            ld_state    <= ld_state_nxt;
            len         <= len_nxt;
            word_lo     <= word_lo_nxt;
            byte_idx    <= byte_idx_nxt;
            word_cnt    <= word_cnt_nxt;
            cksum       <= cksum_nxt;
            program_out <= program_out_nxt;
            address_out <= address_out_nxt;
            write_en    <= write_en_nxt;
            core_reset  <= core_reset_nxt;
            load_done   <= load_done_nxt;
            frame_err   <= frame_err_nxt;
            ovf_err     <= ovf_err_nxt;
            chk_err     <= chk_err_nxt;
        end
    end

    // Loader next state: frame parsing, word assembly and write strobes
    always_comb begin
        ld_state_nxt    = ld_state;
        len_nxt         = len;
        word_lo_nxt     = word_lo;
        byte_idx_nxt    = byte_idx;
        word_cnt_nxt    = word_cnt;
        cksum_nxt       = cksum;
        program_out_nxt = program_out;
        address_out_nxt = address_out;
        write_en_nxt    = 1'b0;
        core_reset_nxt  = core_reset;
        load_done_nxt   = load_done;
        frame_err_nxt   = frame_err;
        ovf_err_nxt     = ovf_err;
        chk_err_nxt     = chk_err;
        last_word       = ((word_cnt + WcntW'(1)) == WcntW'(len));
        word_ovf        = |(word_cnt >> AddrWidth);

        // address steps the cycle after each strobe and saturates instead of wrapping
        if (write_en && (address_out != '1)) begin
            address_out_nxt = address_out + AddrWidth'(1);
        end

        if (frame_evt) begin
            frame_err_nxt = 1'b1;
            ld_state_nxt  = WAIT_SYNC;
        end else if (byte_valid) begin
            case (ld_state)
                WAIT_SYNC, DONE: begin
                    if (rx_shift == SyncByte) begin
                        ld_state_nxt    = LEN_LO;
                        core_reset_nxt  = 1'b1;
                        load_done_nxt   = 1'b0;
                        address_out_nxt = '0;
                    end
                end
                LEN_LO: begin
                    len_nxt[7:0] = rx_shift;
                    ld_state_nxt = LEN_HI;
                end
                LEN_HI: begin
                    len_nxt[15:8] = rx_shift;
                    byte_idx_nxt  = '0;
                    word_cnt_nxt  = '0;
                    cksum_nxt     = '0;
                    ld_state_nxt  = ({rx_shift, len[7:0]} == 16'h0000) ? ImageEnd : DATA;
                end
                DATA: begin
                    cksum_nxt    = cksum + rx_shift;
                    byte_idx_nxt = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    word_lo_nxt[7:0]   = rx_shift;
                        2'd1:    word_lo_nxt[15:8]  = rx_shift;
                        2'd2:    word_lo_nxt[23:16] = rx_shift;
                        default: begin
                            word_cnt_nxt = word_cnt + WcntW'(1);
                            if (word_ovf) begin
                                ovf_err_nxt = 1'b1;
                            end else begin
                                write_en_nxt    = 1'b1;
                                program_out_nxt = DataWidth'({rx_shift, word_lo});
                            end
                            if (last_word) begin
                                ld_state_nxt = ImageEnd;
                            end
                        end
                    endcase
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (rx_shift == cksum) begin
                        ld_state_nxt = DONE;
                    end else begin
                        chk_err_nxt  = 1'b1;
                        ld_state_nxt = WAIT_SYNC;
                    end
                end
`endif
                default: ld_state_nxt = WAIT_SYNC;
            endcase
        end

        // release the core one cycle after DONE is entered, unless a new load starts
        if ((ld_state == DONE) && (ld_state_nxt == DONE)) begin
            core_reset_nxt = 1'b0;
            load_done_nxt  = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader with a fast UART (16 clocks/bit).
// Instance a uses the default 10-bit address; instance b uses a 2-bit address
// to exercise the overflow path.
module tb_uart_program_loader;

    localparam int unsigned CPB = 16;

    typedef logic [7:0] img_t [20];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_a  = 1'b1;
    logic        rx_b  = 1'b1;

    logic [31:0] pa;
    logic [9:0]  aa;
    logic        wea, cra, lda, fea, oea, cea;
    logic [31:0] pb;
    logic [1:0]  ab;
    logic        web, crb, ldb, feb, oeb, ceb;

    int checks = 0;
    int errors = 0;

    int cyc       = 0;
    int we_cyc_a  = 0;
    int last_nd_a = 0;
    int last_cr_a = 0;
    wr_t         wq_a [$];
    logic [1:0]  wq_b_addr [$];
    logic [31:0] wq_b_data [$];

    uart_program_loader #(.DataWidth(32), .AddrWidth(10), .ClksPerBit(CPB)) dut_a (
        .clock(clock), .reset(reset), .uart_rx(rx_a),
        .program_out(pa), .address_out(aa), .write_en(wea),
        .core_reset(cra), .load_done(lda), .frame_err(fea),
        .ovf_err(oea), .chk_err(cea)
    );

    uart_program_loader #(.DataWidth(32), .AddrWidth(2), .ClksPerBit(CPB)) dut_b (
        .clock(clock), .reset(reset), .uart_rx(rx_b),
        .program_out(pb), .address_out(ab), .write_en(web),
        .core_reset(crb), .load_done(ldb), .frame_err(feb),
        .ovf_err(oeb), .chk_err(ceb)
    );

    always #5 clock = ~clock;

    // Write-strobe and release-timing monitor, sampled on the falling edge
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (wea) begin
            wq_a.push_back('{addr: aa, data: pa});
            we_cyc_a <= cyc;
        end
        if (!lda) last_nd_a <= cyc;
        if (cra)  last_cr_a <= cyc;
        if (web) begin
            wq_b_addr.push_back(ab);
            wq_b_data.push_back(pb);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            set_rx(sel, fr[i]);
            repeat (CPB - 1) @(negedge clock);
        end
        @(negedge clock);
        set_rx(sel, 1'b1);
        repeat (4) @(negedge clock);
    endtask

    task automatic send_image(input int sel, input int n, input img_t d);
        logic [7:0] sum;
        sum = 8'h00;
        send_byte(sel, 8'hA5, 1'b1);
        send_byte(sel, 8'(n), 1'b1);
        send_byte(sel, 8'(n >> 8), 1'b1);
        for (int i = 0; i < 4 * n; i++) begin
            send_byte(sel, d[i], 1'b1);
            sum = sum + d[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sel, sum, 1'b1);
`endif
        repeat (8) @(negedge clock);
    endtask

    task automatic do_reset();
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        vec_t vecs [4];
        img_t img;
        int   base;

        vecs[0] = '{b0: 8'h13, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp_word: 32'h0000_0013};
        vecs[1] = '{b0: 8'hEF, b1: 8'hBE, b2: 8'hAD, b3: 8'hDE, exp_word: 32'hDEAD_BEEF};
        vecs[2] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, exp_word: 32'h0403_0201};
        vecs[3] = '{b0: 8'hFF, b1: 8'h00, b2: 8'hFF, b3: 8'h80, exp_word: 32'h80FF_00FF};

        // reset values
        repeat (3) @(negedge clock);
        check("rst_program_out", pa, 32'h0);
        check("rst_address_out", 32'(aa), 32'h0);
        check("rst_write_en", 32'(wea), 32'h0);
        check("rst_core_reset", 32'(cra), 32'h1);
        check("rst_load_done", 32'(lda), 32'h0);
        check("rst_flags", 32'({fea, oea, cea}), 32'h0);
        reset = 1'b1;
        repeat (200) @(negedge clock);
        check("idle_no_writes", 32'(wq_a.size()), 32'h0);
        check("idle_core_reset", 32'(cra), 32'h1);

        // two-word image
        base = wq_a.size();
        img = '{default: 8'h00};
        img[0] = 8'h13;
        img[4] = 8'hB7;
        img[5] = 8'h12;
        send_image(0, 2, img);
        check("img2_count", 32'(wq_a.size() - base), 32'd2);
        check("img2_w0_addr", 32'(wq_a[base].addr), 32'd0);
        check("img2_w0_data", wq_a[base].data, 32'h0000_0013);
        check("img2_w1_addr", 32'(wq_a[base + 1].addr), 32'd1);
        check("img2_w1_data", wq_a[base + 1].data, 32'h0000_12B7);
        check("img2_core_reset", 32'(cra), 32'h0);
        check("img2_load_done", 32'(lda), 32'h1);
`ifndef LOADER_CHECKSUM_EN
        check("img2_done_timing", 32'(last_nd_a), 32'(we_cyc_a));
        check("img2_release_timing", 32'(last_cr_a), 32'(we_cyc_a));
`endif

        // reset in the middle of a byte aborts the load
        send_byte(0, 8'hA5, 1'b1);
        send_byte(0, 8'h02, 1'b1);
        send_byte(0, 8'h00, 1'b1);
        send_byte(0, 8'h11, 1'b1);
        send_byte(0, 8'h22, 1'b1);
        send_byte(0, 8'h33, 1'b1);
        send_byte(0, 8'h44, 1'b1);
        repeat (8) @(negedge clock);
        check("abort_pre_addr", 32'(aa), 32'd1);
        check("abort_pre_data", pa, 32'h4433_2211);
        rx_a = 1'b0;
        repeat (40) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_program_out", pa, 32'h0);
        check("abort_address_out", 32'(aa), 32'h0);
        check("abort_core_reset", 32'(cra), 32'h1);
        check("abort_load_done", 32'(lda), 32'h0);
        rx_a  = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // leading junk then an empty image
        base = wq_a.size();
        send_byte(0, 8'h3C, 1'b1);
        send_byte(0, 8'h5A, 1'b1);
        send_image(0, 0, img);
        check("empty_no_writes", 32'(wq_a.size() - base), 32'd0);
        check("empty_core_reset", 32'(cra), 32'h0);
        check("empty_load_done", 32'(lda), 32'h1);

        // framing error during DATA, then a clean reload from address 0
        do_reset();
        base = wq_a.size();
        send_byte(0, 8'hA5, 1'b1);
        send_byte(0, 8'h02, 1'b1);
        send_byte(0, 8'h00, 1'b1);
        send_byte(0, 8'h11, 1'b1);
        send_byte(0, 8'h22, 1'b1);
        send_byte(0, 8'h33, 1'b1);
        send_byte(0, 8'h44, 1'b1);
        send_byte(0, 8'h55, 1'b0);
        repeat (8) @(negedge clock);
        check("ferr_flag", 32'(fea), 32'h1);
        check("ferr_core_reset", 32'(cra), 32'h1);
        check("ferr_load_done", 32'(lda), 32'h0);
        check("ferr_writes", 32'(wq_a.size() - base), 32'd1);
        base = wq_a.size();
        img = '{default: 8'h00};
        img[0] = 8'hEF; img[1] = 8'hBE; img[2] = 8'hAD; img[3] = 8'hDE;
        send_image(0, 1, img);
        check("ferr_reload_count", 32'(wq_a.size() - base), 32'd1);
        check("ferr_reload_addr", 32'(wq_a[base].addr), 32'd0);
        check("ferr_reload_data", wq_a[base].data, 32'hDEAD_BEEF);
        check("ferr_sticky", 32'(fea), 32'h1);
        check("ferr_reload_done", 32'(lda), 32'h1);

        // table of single-word images, each restarting from DONE
        for (int v = 0; v < 4; v++) begin
            base = wq_a.size();
            img = '{default: 8'h00};
            img[0] = vecs[v].b0;
            img[1] = vecs[v].b1;
            img[2] = vecs[v].b2;
            img[3] = vecs[v].b3;
            send_image(0, 1, img);
            check($sformatf("tbl%0d_count", v), 32'(wq_a.size() - base), 32'd1);
            check($sformatf("tbl%0d_addr", v), 32'(wq_a[base].addr), 32'd0);
            check($sformatf("tbl%0d_data", v), wq_a[base].data, vecs[v].exp_word);
            check($sformatf("tbl%0d_done", v), 32'(lda), 32'h1);
        end

        // overflow on the 2-bit address instance
        do_reset();
        img = '{default: 8'h00};
        for (int k = 0; k < 5; k++) img[4 * k] = 8'(8'hA0 + k);
        send_image(1, 5, img);
        check("ovf_count", 32'(wq_b_addr.size()), 32'd4);
        check("ovf_a0", 32'(wq_b_addr[0]), 32'd0);
        check("ovf_a3", 32'(wq_b_addr[3]), 32'd3);
        check("ovf_d0", wq_b_data[0], 32'h0000_00A0);
        check("ovf_d3", wq_b_data[3], 32'h0000_00A3);
        check("ovf_flag", 32'(oeb), 32'h1);
        check("ovf_load_done", 32'(ldb), 32'h1);
        check("ovf_addr_hold", 32'(ab), 32'd3);
        check("ovf_data_hold", pb, 32'h0000_00A3);
        check("ovf_a_untouched", 32'(oea), 32'h0);

`ifdef LOADER_CHECKSUM_EN
        // checksum match and mismatch
        do_reset();
        base = wq_a.size();
        send_byte(0, 8'hA5, 1'b1);
        send_byte(0, 8'h01, 1'b1);
        send_byte(0, 8'h00, 1'b1);
        send_byte(0, 8'h01, 1'b1);
        send_byte(0, 8'h02, 1'b1);
        send_byte(0, 8'h03, 1'b1);
        send_byte(0, 8'h04, 1'b1);
        send_byte(0, 8'h0A, 1'b1);
        repeat (8) @(negedge clock);
        check("ck_ok_data", wq_a[base].data, 32'h0403_0201);
        check("ck_ok_done", 32'(lda), 32'h1);
        check("ck_ok_flag", 32'(cea), 32'h0);
        do_reset();
        send_byte(0, 8'hA5, 1'b1);
        send_byte(0, 8'h01, 1'b1);
        send_byte(0, 8'h00, 1'b1);
        send_byte(0, 8'h01, 1'b1);
        send_byte(0, 8'h02, 1'b1);
        send_byte(0, 8'h03, 1'b1);
        send_byte(0, 8'h04, 1'b1);
        send_byte(0, 8'h0B, 1'b1);
        repeat (8) @(negedge clock);
        check("ck_bad_flag", 32'(cea), 32'h1);
        check("ck_bad_core_reset", 32'(cra), 32'h1);
        check("ck_bad_load_done", 32'(lda), 32'h0);
`else
        check("chk_err_a_zero", 32'(cea), 32'h0);
        check("chk_err_b_zero", 32'(ceb), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
